// File: rtl/power_core_pkg.sv
// ============================================================================
// Module : power_core_pkg
// Brief  : Shared GPR geometry and writeback request record for the core.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package power_core_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 64;

  typedef struct packed {
    logic [0:GPR_ADDR_W-1] addr;
    logic [0:GPR_DATA_W-1] data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/wb_rr_picker.sv
// ============================================================================
// Module : wb_rr_picker
// Brief  : Combinational find-first-set starting at i_start, wrapping modulo N.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    logic [IW:0] sum;
    o_found = 1'b0;
    o_idx   = '0;
    sum     = '0;
    for (int off = N - 1; off >= 0; off--) begin
      sum = {1'b0, i_start} + (IW+1)'(off);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      if (i_req[sum[IW-1:0]]) begin
        o_found = 1'b1;
        o_idx   = sum[IW-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_arbiter.sv
// ============================================================================
// Module : writeback_arbiter
// Brief  : Grants up to two execution-unit writebacks per cycle onto the two
//          register-unit write ports. WB_ARB_ROUND_ROBIN_EN selects rotating
//          priority; otherwise unit 0 has fixed highest priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_arbiter
  import power_core_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic                                clock_i,
  input  logic                                reset_i,
  input  logic [NUM_UNITS-1:0]                wbValid_i,
  input  logic [0:NUM_UNITS*GPR_ADDR_W-1]     wbAddress_i,
  input  logic [0:NUM_UNITS*GPR_DATA_W-1]     wbData_i,
  output logic [NUM_UNITS-1:0]                wbGrant_o,
  output logic [0:GPR_DATA_W-1]               reg1WritebackData_o,
  output logic [0:GPR_ADDR_W-1]               reg1WritebackAddress_o,
  output logic                                reg1isWriteback_o,
  output logic [0:GPR_DATA_W-1]               reg2WritebackData_o,
  output logic [0:GPR_ADDR_W-1]               reg2WritebackAddress_o,
  output logic                                reg2isWriteback_o,
  output logic                                busy_o
);

  localparam int IDX_W = $clog2(NUM_UNITS);

  function automatic logic [IDX_W-1:0] f_wrapInc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(NUM_UNITS - 1)) ? '0 : idx + 1'b1;
  endfunction

  wb_req_t              w_req [NUM_UNITS];
  logic [IDX_W-1:0]     w_ptr;
  logic                 w_found1;
  logic [IDX_W-1:0]     w_idx1;
  logic                 w_found2;
  logic [IDX_W-1:0]     w_idx2;
  logic [IDX_W-1:0]     w_start2;
  logic [NUM_UNITS-1:0] w_mask2;
  logic [NUM_UNITS-1:0] w_grant;

  logic [0:GPR_DATA_W-1] r_data1;
  logic [0:GPR_ADDR_W-1] r_addr1;
  logic                  r_en1;
  logic [0:GPR_DATA_W-1] r_data2;
  logic [0:GPR_ADDR_W-1] r_addr2;
  logic                  r_en2;

  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_unpack
    assign w_req[k] = {wbAddress_i[k*GPR_ADDR_W +: GPR_ADDR_W],
                       wbData_i[k*GPR_DATA_W +: GPR_DATA_W]};
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_lastIdx;

  assign w_lastIdx = w_found2 ? w_idx2 : w_idx1;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_ptr <= '0;
    end else if (w_found1) begin
      r_ptr <= f_wrapInc(w_lastIdx);
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  wb_rr_picker #(
    .N  (NUM_UNITS),
    .IW (IDX_W)
  ) u_pick1 (
    .i_req   (wbValid_i),
    .i_start (w_ptr),
    .o_found (w_found1),
    .o_idx   (w_idx1)
  );

  // Same-register writes to pick 1 are held back so the older write lands first.
  for (genvar k = 0; k < NUM_UNITS; k++) begin : g_mask2
    assign w_mask2[k] = wbValid_i[k]
                      && (IDX_W'(k) != w_idx1)
                      && (w_req[k].addr != w_req[w_idx1].addr);
  end

  assign w_start2 = f_wrapInc(w_idx1);

  wb_rr_picker #(
    .N  (NUM_UNITS),
    .IW (IDX_W)
  ) u_pick2 (
    .i_req   (w_mask2),
    .i_start (w_start2),
    .o_found (w_found2),
    .o_idx   (w_idx2)
  );

  always_comb begin
    w_grant = '0;
    if (!reset_i) begin
      if (w_found1) w_grant[w_idx1] = 1'b1;
      if (w_found2) w_grant[w_idx2] = 1'b1;
    end
  end

  assign wbGrant_o = w_grant;
  assign busy_o    = |(wbValid_i & ~w_grant);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_en1   <= 1'b0;
      r_addr1 <= '0;
      r_data1 <= '0;
      r_en2   <= 1'b0;
      r_addr2 <= '0;
      r_data2 <= '0;
    end else begin
      r_en1 <= w_found1;
      r_en2 <= w_found2;
      if (w_found1) begin
        r_addr1 <= w_req[w_idx1].addr;
        r_data1 <= w_req[w_idx1].data;
      end
      if (w_found2) begin
        r_addr2 <= w_req[w_idx2].addr;
        r_data2 <= w_req[w_idx2].data;
      end
    end
  end

  assign reg1WritebackData_o    = r_data1;
  assign reg1WritebackAddress_o = r_addr1;
  assign reg1isWriteback_o      = r_en1;
  assign reg2WritebackData_o    = r_data2;
  assign reg2WritebackAddress_o = r_addr2;
  assign reg2isWriteback_o      = r_en2;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// Module : tb_writeback_arbiter
// Brief  : Self-checking bench for writeback_arbiter against a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

  localparam int N = 4;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b1;
  logic [N-1:0]      wbValid_i = '0;
  logic [0:N*5-1]    wbAddress_i = '0;
  logic [0:N*64-1]   wbData_i = '0;
  logic [N-1:0]      wbGrant_o;
  logic [0:63]       reg1WritebackData_o;
  logic [0:4]        reg1WritebackAddress_o;
  logic              reg1isWriteback_o;
  logic [0:63]       reg2WritebackData_o;
  logic [0:4]        reg2WritebackAddress_o;
  logic              reg2isWriteback_o;
  logic              busy_o;

  writeback_arbiter #(.NUM_UNITS(N)) dut (
    .clock_i                (clock_i),
    .reset_i                (reset_i),
    .wbValid_i              (wbValid_i),
    .wbAddress_i            (wbAddress_i),
    .wbData_i               (wbData_i),
    .wbGrant_o              (wbGrant_o),
    .reg1WritebackData_o    (reg1WritebackData_o),
    .reg1WritebackAddress_o (reg1WritebackAddress_o),
    .reg1isWriteback_o      (reg1isWriteback_o),
    .reg2WritebackData_o    (reg2WritebackData_o),
    .reg2WritebackAddress_o (reg2WritebackAddress_o),
    .reg2isWriteback_o      (reg2isWriteback_o),
    .busy_o                 (busy_o)
  );

  always #5 clock_i = ~clock_i;

  // Pending request state of each unit, as the units themselves see it.
  bit          v [N];
  logic [4:0]  a [N];
  logic [63:0] d [N];

  // Expected register-unit port contents and priority pointer.
  bit          m_en1, m_en2;
  logic [4:0]  m_a1, m_a2;
  logic [63:0] m_d1, m_d2;
  int          m_ptr;

  bit          e_f1, e_f2;
  int          e_p1, e_p2;
  logic [N-1:0] e_grant;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [4:0] addr, input logic [63:0] data);
    v[k] = 1'b1;
    a[k] = addr;
    d[k] = data;
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) v[k] = 1'b0;
  endtask

  // Choose the two winners straight from the arbitration rules.
  task automatic model_pick();
    int u;
    e_f1 = 1'b0; e_f2 = 1'b0; e_p1 = 0; e_p2 = 0;
    for (int off = 0; off < N; off++) begin
      u = (m_ptr + off) % N;
      if (!e_f1 && v[u]) begin e_f1 = 1'b1; e_p1 = u; end
    end
    if (e_f1) begin
      for (int off = 1; off < N; off++) begin
        u = (e_p1 + off) % N;
        if (!e_f2 && v[u] && a[u] != a[e_p1]) begin e_f2 = 1'b1; e_p2 = u; end
      end
    end
    e_grant = '0;
    if (!reset_i) begin
      if (e_f1) e_grant[e_p1] = 1'b1;
      if (e_f2) e_grant[e_p2] = 1'b1;
    end
  endtask

  task automatic eval_cycle();
    logic [N-1:0] vmask;
    for (int k = 0; k < N; k++) begin
      wbValid_i[k]           = v[k];
      wbAddress_i[k*5 +: 5]  = a[k];
      wbData_i[k*64 +: 64]   = d[k];
      vmask[k]               = v[k];
    end
    #1;
    model_pick();
    check_eq("grant", wbGrant_o, e_grant);
    check_eq("busy", busy_o, |(vmask & ~e_grant));
  endtask

  task automatic tick();
    @(posedge clock_i);
    cyc++;
    if (reset_i) begin
      m_en1 = 0; m_en2 = 0; m_a1 = 0; m_a2 = 0; m_d1 = 0; m_d2 = 0; m_ptr = 0;
    end else begin
      m_en1 = e_f1;
      m_en2 = e_f2;
      if (e_f1) begin m_a1 = a[e_p1]; m_d1 = d[e_p1]; end
      if (e_f2) begin m_a2 = a[e_p2]; m_d2 = d[e_p2]; end
`ifdef WB_ARB_ROUND_ROBIN_EN
      if (e_f1) m_ptr = ((e_f2 ? e_p2 : e_p1) + 1) % N;
`endif
    end
    for (int k = 0; k < N; k++) if (e_grant[k]) v[k] = 1'b0;
    #1;
    check_eq("p1_en",   reg1isWriteback_o,      m_en1);
    check_eq("p1_addr", reg1WritebackAddress_o, m_a1);
    check_eq("p1_data", reg1WritebackData_o,    m_d1);
    check_eq("p2_en",   reg2isWriteback_o,      m_en2);
    check_eq("p2_addr", reg2WritebackAddress_o, m_a2);
    check_eq("p2_data", reg2WritebackData_o,    m_d2);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, 5'(k + 1), 64'(k + 100));
    eval_cycle();
    check_eq("rst_grant", wbGrant_o, '0);
    tick();
    check_eq("rst_p1_en", reg1isWriteback_o, 1'b0);
    check_eq("rst_p2_en", reg2isWriteback_o, 1'b0);
    reset_i = 1'b0;
    clear_all();
  endtask

  logic [N-1:0] exp_seq [3];

  initial begin
    m_ptr = 0;
    for (int k = 0; k < N; k++) begin v[k] = 0; a[k] = 0; d[k] = 0; end

    do_reset();

    // Single request from unit 2.
    set_req(2, 5'd5, 64'd10);
    eval_cycle();
    check_eq("single_grant", wbGrant_o, 4'b0100);
    tick();
    check_eq("single_p1_addr", reg1WritebackAddress_o, 5);
    check_eq("single_p1_data", reg1WritebackData_o, 10);
    check_eq("single_p2_en", reg2isWriteback_o, 1'b0);

    // Two requests on distinct registers from fresh priority.
    do_reset();
    set_req(0, 5'd2, 64'd5);
    set_req(3, 5'd3, 64'd6);
    eval_cycle();
    check_eq("two_grant", wbGrant_o, 4'b1001);
    tick();
    check_eq("two_p1_addr", reg1WritebackAddress_o, 2);
    check_eq("two_p1_data", reg1WritebackData_o, 5);
    check_eq("two_p2_addr", reg2WritebackAddress_o, 3);
    check_eq("two_p2_data", reg2WritebackData_o, 6);

    // Four units continuously re-requesting.
    do_reset();
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_seq = '{4'b0011, 4'b1100, 4'b0011};
`else
    exp_seq = '{4'b0011, 4'b0011, 4'b0011};
`endif
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < N; k++) set_req(k, 5'(10 + k), 64'(c * 16 + k));
      eval_cycle();
      check_eq("four_grant", wbGrant_o, exp_seq[c]);
      tick();
    end

    // Same destination register: older-by-priority lands first.
    do_reset();
    set_req(0, 5'd7, 64'd1);
    set_req(1, 5'd7, 64'd2);
    eval_cycle();
    check_eq("same_grant0", wbGrant_o, 4'b0001);
    check_eq("same_busy", busy_o, 1'b1);
    tick();
    eval_cycle();
    check_eq("same_grant1", wbGrant_o, 4'b0010);
    tick();
    check_eq("same_reg7_data", reg1WritebackData_o, 2);
    check_eq("same_reg7_addr", reg1WritebackAddress_o, 7);

`ifndef WB_ARB_ROUND_ROBIN_EN
    // Fixed priority lets unit 3 starve behind units 0 and 1.
    do_reset();
    set_req(3, 5'd20, 64'd33);
    for (int c = 0; c < 10; c++) begin
      set_req(0, 5'd21, 64'(c));
      set_req(1, 5'd22, 64'(c + 50));
      eval_cycle();
      check_eq("starve_u3", wbGrant_o[3], 1'b0);
      tick();
    end
    clear_all();
`endif

    // Randomized traffic with occasional mid-stream reset.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      reset_i = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < N; k++) begin
        if (!v[k] && $urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 7) == 0)
            set_req(k, ($urandom_range(0, 1) != 0) ? 5'd0 : 5'd31, {$urandom, $urandom});
          else
            set_req(k, 5'($urandom_range(0, 3)), {$urandom, $urandom});
        end
      end
      eval_cycle();
      tick();
    end
    reset_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
